// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - effective-address calculation and MOV/MOC memory-access sequencer
//
// Purpose: computes the effective address of a load or store, which can be pre- or
// post-indexed and can count up or down. It runs one MOV/MOC handshake per beat and
// supports byte, half and word sizes, sign-extended loads and multi-word bursts. At the
// end it reports the write-back value for the base register.
//
// Ports:
//   main_clk, reset            clock (rising edge), asynchronous active-high reset
//   start, rw, size, sig,      request; all fields are captured when start is accepted
//   pre_index, up, base_addr,  (only while busy=0)
//   offset, count
//   wdata / data_req           store data, which must be valid while data_req=1
//   busy, done, error          operation status; done is a one-cycle pulse
//   rd_valid, rd_data,         per-beat load return with extension; current beat number
//   beat_idx
//   wb_addr                    base register write-back value, valid with done && !error
//   mem_*                      RAM side: address, write data, rw, data length, sig,
//                              mov request, moc completion, read data
//
// DATA_W must be at least 16 and a power of two.
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sig,
    input  logic              pre_index,
    input  logic              up,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] offset,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] wdata,
    output logic              data_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  beat_idx,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic [1:0]        mem_dl,
    output logic              mem_sig,
    output logic              mem_mov,
    input  logic              mem_moc,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BYTES   = DATA_W / 8;
    localparam int ALIGN_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACCESS,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t             state;
    logic               r_pre;
    logic               r_up;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_off;
    logic [CNT_W-1:0]   r_last;     // index of the final beat
    logic [TMR_W-1:0]   timer;

    logic [1:0]         eff_size_c;
    logic [ADDR_W-1:0]  ea_c;
    logic [ADDR_W-1:0]  first_c;
    logic               misaligned_c;
    logic [CNT_W:0]     nbeats_c;
    logic [ADDR_W-1:0]  span_c;
    logic [ADDR_W-1:0]  wb_c;
    logic [DATA_W-1:0]  rd_ext_c;

    // A burst always moves whole words. The reserved size code 11 also means a word.
    assign eff_size_c = (count > CNT_W'(1) || size == 2'b11) ? 2'b10 : size;

    assign ea_c    = r_up ? r_base + r_off : r_base - r_off;
    assign first_c = r_pre ? ea_c : r_base;

    assign misaligned_c = (mem_dl == 2'b01 && first_c[0]) ||
                          (mem_dl == 2'b10 && first_c[ALIGN_W-1:0] != '0);

    // The burst span is nbeats * BYTES. BYTES is a power of two, so this is a shift.
    assign nbeats_c = {1'b0, r_last} + {{CNT_W{1'b0}}, 1'b1};
    assign span_c   = ADDR_W'({nbeats_c, {ALIGN_W{1'b0}}});

    // A single beat writes back base +/- offset for both indexing modes.
    // A burst writes back the address just past the last word it moved.
    assign wb_c = (r_last == '0) ? ea_c
                                 : (r_up ? first_c + span_c : first_c - span_c);

    // RAM data is right-justified. Extend the data to the full width.
    always_comb begin
        rd_ext_c = mem_rdata;
        case (mem_dl)
            2'b00:   rd_ext_c = {{(DATA_W-8){mem_sig & mem_rdata[7]}}, mem_rdata[7:0]};
            2'b01:   rd_ext_c = {{(DATA_W-16){mem_sig & mem_rdata[15]}}, mem_rdata[15:0]};
            default: rd_ext_c = mem_rdata;
        endcase
    end

    // Store data goes straight through to RAM while it is being requested.
    assign mem_wdata = data_req ? wdata : '0;

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            r_pre    <= 1'b0;
            r_up     <= 1'b0;
            r_base   <= '0;
            r_off    <= '0;
            r_last   <= '0;
            timer    <= '0;
            data_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            beat_idx <= '0;
            wb_addr  <= '0;
            mem_addr <= '0;
            mem_rw   <= 1'b0;
            mem_dl   <= 2'b00;
            mem_sig  <= 1'b0;
            mem_mov  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_rw   <= rw;
                        mem_dl   <= eff_size_c;
                        mem_sig  <= sig;
                        r_pre    <= pre_index;
                        r_up     <= up;
                        r_base   <= base_addr;
                        r_off    <= offset;
                        r_last   <= (count == '0) ? '0 : count - CNT_W'(1);
                        beat_idx <= '0;
                        timer    <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    wb_addr <= wb_c;
                    if (misaligned_c) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        mem_addr <= first_c;
                        mem_mov  <= 1'b1;
                        data_req <= ~mem_rw;
                        timer    <= '0;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A completion in the cycle where the timer expires still counts.
                    if (mem_moc) begin
                        mem_mov  <= 1'b0;
                        data_req <= 1'b0;
                        if (mem_rw) begin
                            rd_valid <= 1'b1;
                            rd_data  <= rd_ext_c;
                        end
                        if (beat_idx == r_last) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        mem_mov  <= 1'b0;
                        data_req <= 1'b0;
                        error    <= 1'b1;
                        done     <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_NEXT: begin
                    // The beat index and address advance only here. They still describe
                    // the completed beat while its rd_valid is high.
                    beat_idx <= beat_idx + CNT_W'(1);
                    mem_addr <= r_up ? mem_addr + ADDR_W'(BYTES) : mem_addr - ADDR_W'(BYTES);
                    mem_mov  <= 1'b1;
                    data_req <= ~mem_rw;
                    timer    <= '0;
                    state    <= S_ACCESS;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          main_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          rw = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sig = 1'b0;
    logic          pre_index = 1'b0;
    logic          up = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] offset = '0;
    logic [CW-1:0] count = '0;
    logic [DW-1:0] wdata = '0;
    logic          data_req, busy, done, error, rd_valid;
    logic [DW-1:0] rd_data, mem_wdata;
    logic [CW-1:0] beat_idx;
    logic [AW-1:0] wb_addr, mem_addr;
    logic          mem_rw, mem_sig, mem_mov;
    logic [1:0]    mem_dl;
    logic          mem_moc = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .main_clk(main_clk), .reset(reset), .start(start), .rw(rw), .size(size), .sig(sig),
        .pre_index(pre_index), .up(up), .base_addr(base_addr), .offset(offset), .count(count),
        .wdata(wdata), .data_req(data_req), .busy(busy), .done(done), .error(error),
        .rd_valid(rd_valid), .rd_data(rd_data), .beat_idx(beat_idx), .wb_addr(wb_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_dl(mem_dl),
        .mem_sig(mem_sig), .mem_mov(mem_mov), .mem_moc(mem_moc), .mem_rdata(mem_rdata)
    );

    always #5 main_clk = ~main_clk;

    // One entry per clock cycle: the inputs to drive and the outputs expected in that cycle.
    typedef struct {
        bit          start;
        bit          moc;
        logic [31:0] mrd;
        bit          busy;
        bit          mov;
        bit          done;
        bit          err;
        bit          rdv;
        int          addr;
        int          beat;
        logic [31:0] rd;
    } cyc_t;

    cyc_t        plan[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          dly[16];
    logic [31:0] dat[16];
    int          q_rw, q_size, q_sig, q_pre, q_up, q_base, q_off, q_count;
    int          exp_wb, exp_esz, p_done_idx, p_addr0;
    logic [31:0] p_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extend(input int esz, input int s, input logic [31:0] d);
        logic [31:0] v;
        if (esz == 0) begin
            v = d & 32'hFF;
            if (s != 0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (esz == 1) begin
            v = d & 32'hFFFF;
            if (s != 0 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic cyc_t blank();
        cyc_t r;
        r = '{default: 0};
        return r;
    endfunction

    // Expected cycle trace for the request held in q_*, using per-beat moc delays and data.
    task automatic build_plan();
        cyc_t r;
        int   n, ea, first, a;
        bit   mis, stop;
        plan.delete();
        n       = (q_count == 0) ? 1 : q_count;
        exp_esz = (q_count > 1 || q_size == 3) ? 2 : q_size;
        ea      = (q_up != 0 ? q_base + q_off : q_base - q_off) & 1023;
        first   = (q_pre != 0) ? ea : q_base;
        mis     = (exp_esz == 1 && first % 2 != 0) || (exp_esz == 2 && first % 4 != 0);
        exp_wb  = (n == 1) ? ea : ((q_up != 0 ? first + n * 4 : first - n * 4) & 1023);
        p_addr0 = first;
        p_rd    = '0;
        r = blank(); r.start = 1; plan.push_back(r);
        r = blank(); r.busy = 1; plan.push_back(r);
        if (mis) begin
            r = blank(); r.busy = 1; r.done = 1; r.err = 1; plan.push_back(r);
        end else begin
            stop = 0;
            for (int b = 0; b < n && !stop; b++) begin
                a = (q_up != 0 ? first + b * 4 : first - b * 4) & 1023;
                for (int c = 0; c < dly[b] && c < TO; c++) begin
                    r = blank(); r.busy = 1; r.mov = 1; r.addr = a; r.beat = b;
                    r.mrd = $urandom; plan.push_back(r);
                end
                if (dly[b] >= TO) begin
                    r = blank(); r.busy = 1; r.done = 1; r.err = 1; plan.push_back(r);
                    stop = 1;
                end else begin
                    r = blank(); r.busy = 1; r.mov = 1; r.addr = a; r.beat = b;
                    r.moc = 1; r.mrd = dat[b]; plan.push_back(r);
                    r = blank(); r.busy = 1; r.rdv = (q_rw != 0); r.beat = b;
                    r.rd = extend(exp_esz, q_sig, dat[b]);
                    if (q_rw != 0 && b == 0) p_rd = r.rd;
                    if (b == n - 1) r.done = 1;
                    plan.push_back(r);
                end
            end
        end
        r = blank(); plan.push_back(r);
        p_done_idx = -1;
        foreach (plan[i]) if (plan[i].done) p_done_idx = i;
    endtask

    // Compare process: checks every cycle of the plan and drives that cycle's inputs.
    task automatic run_plan(input int limit);
        cyc_t r;
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            r = plan[i];
            @(negedge main_clk);
            chk("busy", busy, r.busy);
            chk("mem_mov", mem_mov, r.mov);
            chk("done", done, r.done);
            chk("rd_valid", rd_valid, r.rdv);
            if (r.done) chk("error", error, r.err);
            if (r.done && !r.err) chk("wb_addr", wb_addr, exp_wb);
            if (r.mov) begin
                chk("mem_addr", mem_addr, r.addr);
                chk("mem_rw", mem_rw, q_rw);
                chk("mem_dl", mem_dl, exp_esz);
                chk("data_req", data_req, q_rw == 0);
                chk("beat_idx", beat_idx, r.beat);
                if (q_rw == 0) chk("mem_wdata", mem_wdata, wdata);
            end
            if (r.rdv) begin
                chk("rd_data", rd_data, r.rd);
                chk("rd_beat_idx", beat_idx, r.beat);
            end
            start     = r.start;
            mem_moc   = r.moc;
            mem_rdata = r.mrd;
        end
    endtask

    task automatic setup_tx(input int t_rw, input int t_size, input int t_sig, input int t_pre,
                            input int t_up, input int t_base, input int t_off, input int t_count);
        q_rw = t_rw; q_size = t_size; q_sig = t_sig; q_pre = t_pre; q_up = t_up;
        q_base = t_base; q_off = t_off; q_count = t_count;
        rw = 1'(t_rw); size = 2'(t_size); sig = 1'(t_sig); pre_index = 1'(t_pre);
        up = 1'(t_up); base_addr = AW'(t_base); offset = AW'(t_off); count = CW'(t_count);
        wdata = $urandom;
        build_plan();
    endtask

    task automatic test1();
        dly[0] = 0; dat[0] = 32'h0000_00F0;
        setup_tx(1, 0, 1, 1, 1, 'h10, 3, 1);
        chk("t1_model_addr", p_addr0, 'h13);
        chk("t1_model_rd", p_rd, 32'hFFFF_FFF0);
        chk("t1_model_done_cycle", p_done_idx, 3);
        chk("t1_model_wb", exp_wb, 'h13);
        run_plan(1000);
    endtask

    int r0;

    initial begin
        #3;
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_error", error, 0);    chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0); chk("rst_beat_idx", beat_idx, 0);
        chk("rst_wb_addr", wb_addr, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mov", mem_mov, 0); chk("rst_data_req", data_req, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_dl", mem_dl, 0);   chk("rst_mem_sig", mem_sig, 0);
        @(negedge main_clk);
        reset = 1'b0;

        test1();

        dly[0] = 1;
        setup_tx(0, 2, 0, 0, 0, 'h40, 8, 1);
        chk("t2_model_wb", exp_wb, 'h38);
        run_plan(1000);

        for (int b = 0; b < 4; b++) begin dly[b] = 0; dat[b] = $urandom; end
        setup_tx(1, 0, 0, 0, 1, 'h100, 'h20, 4);
        chk("t3_model_wb", exp_wb, 'h110);
        chk("t3_model_done_cycle", p_done_idx, 9);
        run_plan(1000);

        dly[0] = TO;
        setup_tx(1, 2, 0, 0, 1, 'h80, 0, 1);
        chk("t4_model_done_cycle", p_done_idx, 2 + TO);
        run_plan(1000);

        setup_tx(1, 1, 0, 1, 1, 'h20, 1, 1);
        chk("t5_model_done_cycle", p_done_idx, 2);
        run_plan(1000);

        // Reset pulse between clock edges in the middle of an ACCESS wait.
        dly[0] = 5; dat[0] = 32'h0000_00F0;
        setup_tx(1, 0, 1, 1, 1, 'h10, 3, 1);
        run_plan(5);
        #2 reset = 1'b1;
        #1;
        chk("t6_mov_async", mem_mov, 0);
        chk("t6_busy_async", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        mem_moc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge main_clk);
            chk("t6_no_done", done, 0);
            chk("t6_idle", busy, 0);
        end
        test1();

        for (int t = 0; t < 60; t++) begin
            for (int b = 0; b < 16; b++) begin
                r0 = $urandom_range(0, 19);
                dly[b] = (r0 < 14) ? r0 % 4 : ((r0 < 17) ? TO - 1 : TO);
                dat[b] = $urandom;
            end
            r0 = $urandom_range(0, 1);
            setup_tx($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1),
                     r0 ? ($urandom_range(0, 1023) & ~3) : $urandom_range(0, 1023),
                     r0 ? ($urandom_range(0, 63) & ~3) : $urandom_range(0, 63),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 1));
            run_plan(1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
